lp_issue: RTL and testbench

Upstream feeder for the brute-force `LP` solver. It accepts linear-program descriptions as a ready/valid word stream and buffers up to `NSLOT` complete problems. It screens each problem for a closed bounding box, then replays each valid problem to the solver as the exact 7-cycle `in_valid` burst the solver requires. It returns one in-order result per problem: the solver's maximum, or an error marker for rejected problems.

---
 rtl/lp_pkg.sv | 28 ++
 rtl/lp_prob_buf.sv | 142 ++++++++++++++
 rtl/lp_issue.sv | 142 ++++++++++++++
 tb/tb_lp_issue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// ---------------------------------------------------------------------------
// lp_pkg : shared types and constants for the LP solver feeder.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lp_pkg;

  typedef struct packed {
    logic signed [5:0]  a1;
    logic signed [5:0]  a2;
    logic signed [11:0] b;
  } lp_word_t;

  localparam int WORDS_PER_PROB = 7;
  localparam int NCON           = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } issue_state_e;

  localparam logic signed [11:0] B_MIN = -12'sd2048;

endpackage

`default_nettype wire

// File: rtl/lp_prob_buf.sv
// ---------------------------------------------------------------------------
// lp_prob_buf : whole-problem slot buffer with bounding-box screening. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lp_prob_buf
  import lp_pkg::*;
#(
  parameter int NSLOT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [5:0]  s_a1,
  input  logic [5:0]  s_a2,
  input  logic [11:0] s_b,
  input  logic [2:0]  rd_idx,
  input  logic        free,
  output logic        head_full,
  output logic        head_valid,
  output logic [23:0] rd_word
);

  localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  lp_word_t          mem_q [NSLOT][WORDS_PER_PROB];
  logic [NSLOT-1:0]  occ_q, occ_d, vld_q, vld_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [3:0]        seen_q, seen_d, seen_n;
  logic signed [11:0] xmax_q, xmax_d, xmax_n, xmin_q, xmin_d, xmin_n;
  logic signed [11:0] ymax_q, ymax_d, ymax_n, ymin_q, ymin_d, ymin_n;
  logic signed [12:0] xlo, xhi, ylo, yhi;
  logic              s_ready_q, s_ready_d;
  logic              wr_en, hit_xmax, hit_xmin, hit_ymax, hit_ymin;
  lp_word_t          w_in;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NSLOT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_in  = {s_a1, s_a2, s_b};
  assign wr_en = s_valid && s_ready_q;

  // Only constraint words (1..6) take part in the box screen.
  assign hit_xmax = (wcnt_q != 3'd0) && (w_in.a1 == 6'sd1)  && (w_in.a2 == 6'sd0);
  assign hit_xmin = (wcnt_q != 3'd0) && (w_in.a1 == -6'sd1) && (w_in.a2 == 6'sd0);
  assign hit_ymax = (wcnt_q != 3'd0) && (w_in.a1 == 6'sd0)  && (w_in.a2 == 6'sd1);
  assign hit_ymin = (wcnt_q != 3'd0) && (w_in.a1 == 6'sd0)  && (w_in.a2 == -6'sd1);

  always_comb begin
    seen_n = seen_q | {hit_ymin, hit_ymax, hit_xmin, hit_xmax};
    xmax_n = (hit_xmax && (w_in.b < xmax_q)) ? w_in.b : xmax_q;
    xmin_n = (hit_xmin && (w_in.b < xmin_q)) ? w_in.b : xmin_q;
    ymax_n = (hit_ymax && (w_in.b < ymax_q)) ? w_in.b : ymax_q;
    ymin_n = (hit_ymin && (w_in.b < ymin_q)) ? w_in.b : ymin_q;
    // One extra bit so that negating B_MIN cannot wrap.
    xlo = -{xmin_n[11], xmin_n};
    xhi = {xmax_n[11], xmax_n};
    ylo = -{ymin_n[11], ymin_n};
    yhi = {ymax_n[11], ymax_n};
  end

  always_comb begin
    occ_d  = occ_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    wcnt_d = wcnt_q;
    seen_d = seen_q;
    xmax_d = xmax_q;
    xmin_d = xmin_q;
    ymax_d = ymax_q;
    ymin_d = ymin_q;
    if (free) begin
      occ_d[head_q] = 1'b0;
      head_d        = nxt(head_q);
    end
    if (wr_en) begin
      if (wcnt_q == 3'(NCON)) begin
        occ_d[tail_q] = 1'b1;
        vld_d[tail_q] = (&seen_n) && (xlo <= xhi) && (ylo <= yhi);
        tail_d        = nxt(tail_q);
        wcnt_d        = 3'd0;
        seen_d        = 4'd0;
        xmax_d        = ~B_MIN;
        xmin_d        = ~B_MIN;
        ymax_d        = ~B_MIN;
        ymin_d        = ~B_MIN;
      end else begin
        wcnt_d = wcnt_q + 3'd1;
        seen_d = seen_n;
        xmax_d = xmax_n;
        xmin_d = xmin_n;
        ymax_d = ymax_n;
        ymin_d = ymin_n;
      end
    end
    s_ready_d = ~occ_d[tail_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= '0;
      vld_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      wcnt_q    <= 3'd0;
      seen_q    <= 4'd0;
      xmax_q    <= ~B_MIN;
      xmin_q    <= ~B_MIN;
      ymax_q    <= ~B_MIN;
      ymin_q    <= ~B_MIN;
      s_ready_q <= 1'b1;
    end else begin
      occ_q     <= occ_d;
      vld_q     <= vld_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      wcnt_q    <= wcnt_d;
      seen_q    <= seen_d;
      xmax_q    <= xmax_d;
      xmin_q    <= xmin_d;
      ymax_q    <= ymax_d;
      ymin_q    <= ymin_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q][wcnt_q] <= w_in;
  end

  assign s_ready    = s_ready_q;
  assign head_full  = occ_q[head_q];
  assign head_valid = vld_q[head_q];
  assign rd_word    = mem_q[head_q][rd_idx];

endmodule

`default_nettype wire

// File: rtl/lp_issue.sv
// ---------------------------------------------------------------------------
// lp_issue : replays buffered problems to the LP solver, returns results. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lp_issue #(
  parameter int NSLOT = 2,
  parameter int GAP   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [5:0]  s_a1,
  input  logic [5:0]  s_a2,
  input  logic [11:0] s_b,
  output logic        lp_in_valid,
  output logic [5:0]  lp_a1,
  output logic [5:0]  lp_a2,
  output logic [11:0] lp_b,
  input  logic        lp_out_valid,
  input  logic [11:0] lp_out_max_value,
  output logic        res_valid,
  output logic [11:0] res_value,
  output logic        res_err
);

  import lp_pkg::*;

  // The local GAP parameter shadows the package state name, hence the qualified refs.
  localparam logic [1:0] S_IDLE  = lp_pkg::IDLE;
  localparam logic [1:0] S_ISSUE = lp_pkg::ISSUE;
  localparam logic [1:0] S_WAIT  = lp_pkg::WAIT;
  localparam logic [1:0] S_GAP   = lp_pkg::GAP;
  localparam int         GW      = (GAP > 1) ? $clog2(GAP) : 1;

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d, rd_idx;
  logic [GW-1:0] gap_q, gap_d;
  logic          lp_in_valid_q, lp_in_valid_d;
  lp_word_t      lp_word_q, lp_word_d, head_word;
  logic          res_valid_q, res_valid_d, res_err_q, res_err_d;
  logic [11:0]   res_value_q, res_value_d;
  logic          head_full, head_valid, free;

  lp_prob_buf #(.NSLOT(NSLOT)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a1       (s_a1),
    .s_a2       (s_a2),
    .s_b        (s_b),
    .rd_idx     (rd_idx),
    .free       (free),
    .head_full  (head_full),
    .head_valid (head_valid),
    .rd_word    (head_word)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    lp_in_valid_d = 1'b0;
    lp_word_d     = '0;
    res_valid_d   = 1'b0;
    res_value_d   = res_value_q;
    res_err_d     = res_err_q;
    free          = 1'b0;
    rd_idx        = (state_q == S_ISSUE) ? cnt_q : 3'd0;
    case (state_q)
      S_IDLE: begin
        if (head_full && head_valid) begin
          lp_in_valid_d = 1'b1;
          lp_word_d     = head_word;
          cnt_d         = 3'd1;
          state_d       = S_ISSUE;
        end else if (head_full) begin
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_value_d = 12'd0;
          free        = 1'b1;
        end
      end
      S_ISSUE: begin
        lp_in_valid_d = 1'b1;
        lp_word_d     = head_word;
        if (cnt_q == 3'(NCON)) state_d = S_WAIT;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      S_WAIT: begin
        if (lp_out_valid) begin
          res_valid_d = 1'b1;
          res_err_d   = 1'b0;
          res_value_d = lp_out_max_value;
          free        = 1'b1;
          gap_d       = '0;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      gap_q         <= '0;
      lp_in_valid_q <= 1'b0;
      lp_word_q     <= '0;
      res_valid_q   <= 1'b0;
      res_value_q   <= 12'd0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      lp_in_valid_q <= lp_in_valid_d;
      lp_word_q     <= lp_word_d;
      res_valid_q   <= res_valid_d;
      res_value_q   <= res_value_d;
      res_err_q     <= res_err_d;
    end
  end

  assign lp_in_valid = lp_in_valid_q;
  assign lp_a1       = lp_word_q.a1;
  assign lp_a2       = lp_word_q.a2;
  assign lp_b        = lp_word_q.b;
  assign res_valid   = res_valid_q;
  assign res_value   = res_value_q;
  assign res_err     = res_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lp_issue.sv
// ---------------------------------------------------------------------------
// tb_lp_issue : directed scoreboard bench for lp_issue with a solver model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lp_issue;
  import lp_pkg::*;

  localparam int NSLOT = 2;
  localparam int GAPC  = 2;
  localparam int LAT   = 3;

  typedef lp_word_t prob_t [WORDS_PER_PROB];
  typedef struct packed {
    logic        err;
    logic [11:0] val;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [5:0]  s_a1 = '0, s_a2 = '0;
  logic [11:0] s_b = '0;
  logic        lp_in_valid;
  logic [5:0]  lp_a1, lp_a2;
  logic [11:0] lp_b;
  logic        lp_out_valid = 1'b0;
  logic [11:0] lp_out_max_value = '0;
  logic        res_valid;
  logic [11:0] res_value;
  logic        res_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  lp_word_t    exp_burst[$];
  res_t        exp_res[$];
  logic [11:0] ret_q[$];

  lp_issue #(.NSLOT(NSLOT), .GAP(GAPC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_a1             (s_a1),
    .s_a2             (s_a2),
    .s_b              (s_b),
    .lp_in_valid      (lp_in_valid),
    .lp_a1            (lp_a1),
    .lp_a2            (lp_a2),
    .lp_b             (lp_b),
    .lp_out_valid     (lp_out_valid),
    .lp_out_max_value (lp_out_max_value),
    .res_valid        (res_valid),
    .res_value        (res_value),
    .res_err          (res_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic lp_word_t wd(input int a1, input int a2, input int b);
    lp_word_t w;
    w.a1 = 6'(a1);
    w.a2 = 6'(a2);
    w.b  = 12'(b);
    return w;
  endfunction

  // Independent screen: all four unit directions present and a non-empty box.
  function automatic bit model_valid(input prob_t p);
    int xh = 100000, xl = 100000, yh = 100000, yl = 100000;
    bit fxh = 0, fxl = 0, fyh = 0, fyl = 0;
    for (int i = 1; i < WORDS_PER_PROB; i++) begin
      int a1, a2, b;
      a1 = int'(p[i].a1);
      a2 = int'(p[i].a2);
      b  = int'(p[i].b);
      if (a1 == 1  && a2 == 0)  begin fxh = 1; if (b < xh) xh = b; end
      if (a1 == -1 && a2 == 0)  begin fxl = 1; if (b < xl) xl = b; end
      if (a1 == 0  && a2 == 1)  begin fyh = 1; if (b < yh) yh = b; end
      if (a1 == 0  && a2 == -1) begin fyl = 1; if (b < yl) yl = b; end
    end
    return fxh && fxl && fyh && fyl && (-xl <= xh) && (-yl <= yh);
  endfunction

  task automatic send_word(input lp_word_t w);
    int t = 0;
    s_valid = 1'b1;
    s_a1 = w.a1;
    s_a2 = w.a2;
    s_b  = w.b;
    while (!s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("s_ready_wait", s_ready, 1);
    @(negedge clk);
  endtask

  task automatic submit(input prob_t p, input logic [11:0] ret, input bit keep);
    if (model_valid(p)) begin
      foreach (p[i]) exp_burst.push_back(p[i]);
      exp_res.push_back('{err: 1'b0, val: ret});
      ret_q.push_back(ret);
    end else begin
      exp_res.push_back('{err: 1'b1, val: 12'd0});
    end
    foreach (p[i]) send_word(p[i]);
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_res.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_results", exp_res.size(), 0);
    repeat (GAPC + 3) @(negedge clk);
  endtask

  // Solver model: checks bursts against the queue and answers after LAT idle cycles.
  initial begin : solver
    int bcnt = 0, wcnt = 0, last_ov = 0;
    bit pend = 0, have_ov = 0, ov_prev = 0;
    logic [11:0] rv = '0;
    lp_word_t w;
    forever begin
      @(negedge clk);
      lp_out_valid = 1'b0;
      if (!rst_n) begin
        bcnt = 0; pend = 0; have_ov = 0; ov_prev = 0;
        continue;
      end
      if (ov_prev) begin
        check("res_latency", res_valid, 1);
        check("res_latency_val", res_value, rv);
        ov_prev = 0;
      end
      if (lp_in_valid) begin
        if (bcnt == 0 && have_ov) check("burst_gap", (cyc - last_ov) >= (GAPC + 1), 1);
        check("burst_expected", exp_burst.size() != 0, 1);
        if (exp_burst.size() != 0) begin
          w = exp_burst.pop_front();
          check("burst_word", {lp_a1, lp_a2, lp_b}, w);
        end
        bcnt++;
        if (bcnt == WORDS_PER_PROB) begin
          bcnt = 0; pend = 1; wcnt = LAT;
        end
      end else begin
        if (bcnt != 0) check("burst_bubble", lp_in_valid, 1);
        check("lp_data_idle_zero", {lp_a1, lp_a2, lp_b}, 0);
        if (pend) begin
          if (wcnt == 0) begin
            rv = (ret_q.size() != 0) ? ret_q.pop_front() : 12'd0;
            lp_out_valid     = 1'b1;
            lp_out_max_value = rv;
            last_ov = cyc; have_ov = 1; pend = 0; ov_prev = 1;
          end else begin
            wcnt--;
          end
        end
      end
    end
  end

  initial begin : res_mon
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        check("res_expected", exp_res.size() != 0, 1);
        if (exp_res.size() != 0) begin
          e = exp_res.pop_front();
          check("res_err", res_err, e.err);
          check("res_value", res_value, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    prob_t p1, p2, p3, pa, pb, pc, pd, pe;
    int t;
    p1 = '{wd(1,1,0), wd(1,0,3), wd(-1,0,0), wd(0,1,2), wd(0,-1,0), wd(1,1,4), wd(1,-1,5)};
    p2 = '{wd(1,1,0), wd(1,0,3), wd(-1,0,0), wd(0,1,2), wd(1,1,9), wd(1,1,4), wd(1,-1,5)};
    p3 = '{wd(1,1,0), wd(1,0,3), wd(-1,0,-5), wd(0,1,2), wd(0,-1,0), wd(1,1,4), wd(1,-1,5)};
    pa = '{wd(2,-1,7), wd(1,0,-2), wd(-1,0,5), wd(0,-1,1), wd(0,1,6), wd(3,3,20), wd(-1,0,4)};
    pb = '{wd(0,1,-3), wd(1,0,3), wd(-1,0,-3), wd(0,1,4), wd(0,-1,4), wd(2,2,2), wd(1,0,9)};
    pc = '{wd(1,0,0), wd(1,0,2047), wd(-1,0,-2048), wd(0,1,0), wd(0,-1,0), wd(0,0,0), wd(0,0,0)};
    pd = '{wd(-1,2,0), wd(1,0,2047), wd(-1,0,-2047), wd(0,1,10), wd(0,-1,0), wd(0,0,1), wd(1,1,1)};
    pe = '{wd(1,1,0), wd(1,0,3), wd(-1,1,0), wd(0,1,2), wd(0,-1,0), wd(1,1,4), wd(1,-1,5)};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_lp_in_valid", lp_in_valid, 0);
    check("rst_lp_data", {lp_a1, lp_a2, lp_b}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_value", res_value, 0);
    check("rst_res_err", res_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic problem: burst one cycle after the slot becomes full.
    submit(p1, 12'd4, 1'b0);
    check("pre_burst", lp_in_valid, 0);
    @(negedge clk);
    check("burst_start", lp_in_valid, 1);
    drain();

    // Missing y-min: error result one cycle after the slot fills.
    submit(p2, 12'd0, 1'b0);
    check("err_pre", res_valid, 0);
    @(negedge clk);
    check("err_latency", res_valid, 1);
    check("err_flag", res_err, 1);
    check("err_no_burst", lp_in_valid, 0);
    drain();

    // Empty x box.
    submit(p3, 12'd0, 1'b0);
    drain();

    // Three back-to-back problems, last one invalid at the B_MIN boundary.
    submit(pa, 12'(-7), 1'b1);
    submit(pb, 12'd100, 1'b1);
    check("ready_drop", s_ready, 0);
    submit(pc, 12'd0, 1'b0);
    drain();

    // Invalid problem queued behind a running valid one.
    submit(pd, 12'(-2048), 1'b1);
    submit(pe, 12'd0, 1'b0);
    drain();

    // Reset in the third burst cycle.
    submit(p1, 12'd4, 1'b0);
    t = 0;
    while (!lp_in_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("burst_seen", lp_in_valid, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_lp_in_valid", lp_in_valid, 0);
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_s_ready", s_ready, 1);
    exp_burst.delete();
    exp_res.delete();
    ret_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_idle", lp_in_valid, 0);
    check("post_rst_ready", s_ready, 1);
    submit(p1, 12'd4, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
